// File: rtl/multiport_register_file.sv
// -----------------------------------------------------------------------------
// multiport_register_file
//
// Register file with one byte-enabled write port and two independent
// registered read ports (A and B). Every entry carries a valid bit that is set
// by any write with at least one byte enable high and cleared only by reset.
// A read that targets the entry being written on the same edge returns the
// post-write merged value (bypass). With R0_ZERO=1, entry 0 is hardwired to
// zero and always reads back as valid.
//
// Parameters
//   DATA_W  : register width in bits (multiple of 8)
//   ADDR_W  : address width, DEPTH = 2**ADDR_W
//   R0_ZERO : 1 = entry 0 reads as zero and ignores writes
//
// Ports
//   clk            : single clock, all state updates on the rising edge
//   reset          : synchronous active-high reset (clears storage + outputs)
//   we             : write enable
//   wAddr          : write address
//   wData          : write data
//   wBe            : byte enables, bit i selects wData[8i+7:8i]
//   rAddrA/rAddrB  : read addresses
//   rDataA/rDataB  : registered read data (1-cycle latency)
//   rValidA/rValidB: registered "entry written since reset" flags
// -----------------------------------------------------------------------------
module multiport_register_file #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 3,
    parameter int R0_ZERO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wAddr,
    input  logic [DATA_W-1:0]     wData,
    input  logic [DATA_W/8-1:0]   wBe,
    input  logic [ADDR_W-1:0]     rAddrA,
    input  logic [ADDR_W-1:0]     rAddrB,
    output logic [DATA_W-1:0]     rDataA,
    output logic [DATA_W-1:0]     rDataB,
    output logic                  rValidA,
    output logic                  rValidB
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;
    localparam int NPORTS = 2;

    generate
        if ((DATA_W % 8) != 0 || DATA_W < 8) begin : gBadWidth
            $error("multiport_register_file: DATA_W must be a positive multiple of 8");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Write-side decode
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] byteMask;     // wBe expanded to one bit per data bit
    logic              writeAny;     // a write that changes something
    logic              writeBlocked; // write aimed at a hardwired-zero entry 0
    logic              writeEff;     // write that actually lands in storage
    logic [DATA_W-1:0] mergedData;   // post-write value of entry wAddr

    genvar gi;

    generate
        for (gi = 0; gi < NBYTES; gi++) begin : gByteMask
            assign byteMask[gi*8 +: 8] = {8{wBe[gi]}};
        end
    endgenerate

    assign writeAny     = we & (|wBe);
    assign writeBlocked = (R0_ZERO != 0) && (wAddr == '0);
    assign writeEff     = writeAny & ~writeBlocked;

    // Storage outputs, one element per entry, each driven by its own
    // generate block so no array element has more than one driver.
    logic [DATA_W-1:0] entryData  [DEPTH];
    logic              entryValid [DEPTH];

    // The merge reads the current contents of the target entry; bytes whose
    // enable is low keep their old value.
    assign mergedData = (entryData[wAddr] & ~byteMask) | (wData & byteMask);

    // -------------------------------------------------------------------------
    // Storage: one flip-flop word plus a valid flag per entry
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gEntry
            if ((R0_ZERO != 0) && (gi == 0)) begin : gZero
                // Hardwired entry: no storage at all, always valid.
                assign entryData[gi]  = '0;
                assign entryValid[gi] = 1'b1;
            end else begin : gStore
                logic [DATA_W-1:0] dataReg;
                logic              validReg;
                logic              hit;

                assign hit = writeEff && (wAddr == ADDR_W'(gi));

                // Reset wins over a simultaneous write.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        dataReg  <= '0;
                        validReg <= 1'b0;
                    end else if (hit) begin
                        dataReg  <= mergedData;
                        validReg <= 1'b1;
                    end
                end

                assign entryData[gi]  = dataReg;
                assign entryValid[gi] = validReg;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read ports: identical logic instantiated per port
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] portAddr  [NPORTS];
    logic [DATA_W-1:0] portData  [NPORTS];
    logic              portValid [NPORTS];

    assign portAddr[0] = rAddrA;
    assign portAddr[1] = rAddrB;

    generate
        for (gi = 0; gi < NPORTS; gi++) begin : gReadPort
            logic [DATA_W-1:0] dataNext;
            logic              validNext;
            logic [DATA_W-1:0] dataReg;
            logic              validReg;

            always_comb begin
                dataNext  = entryData[portAddr[gi]];
                validNext = entryValid[portAddr[gi]];
                // Same-edge write to the addressed entry: return the value the
                // entry will hold after this edge.
                if (writeEff && (portAddr[gi] == wAddr)) begin
                    dataNext  = mergedData;
                    validNext = 1'b1;
                end
                // A blocked write to entry 0 never reaches writeEff, and the
                // zero entry already reads as 0/valid, so no extra case here.
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    dataReg  <= '0;
                    validReg <= 1'b0;
                end else begin
                    dataReg  <= dataNext;
                    validReg <= validNext;
                end
            end

            assign portData[gi]  = dataReg;
            assign portValid[gi] = validReg;
        end
    endgenerate

    assign rDataA  = portData[0];
    assign rDataB  = portData[1];
    assign rValidA = portValid[0];
    assign rValidB = portValid[1];

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 3, giving the address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter R0_ZERO, default 0; when 1, entry 0 is hardwired to zero.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port we, input, 1 bit: write enable.
REQ-007 The block SHALL have port wAddr, input, ADDR_W bits: write address.
REQ-008 The block SHALL have port wData, input, DATA_W bits: write data.
REQ-009 The block SHALL have port wBe, input, DATA_W/8 bits: byte enables; bit i selects wData[8i+7:8i].
REQ-010 The block SHALL have ports rAddrA and rAddrB, input, ADDR_W bits each: read addresses for ports A and B.
REQ-011 The block SHALL have ports rDataA and rDataB, output, DATA_W bits each: registered read data.
REQ-012 The block SHALL have ports rValidA and rValidB, output, 1 bit each: set when the returned entry has been written since reset.

Function
REQ-013 A write SHALL occur at a rising clk edge when we=1 and reset=0: for each i with wBe[i]=1, byte i of entry wAddr takes byte i of wData; bytes with wBe[i]=0 SHALL be unchanged.
REQ-014 A write with we=1 and wBe all-zero SHALL change no data and SHALL NOT set the valid bit.
REQ-015 Each entry SHALL carry a valid bit, set on any write with at least one wBe bit high, and cleared only by reset.
REQ-016 Reads SHALL have 1-cycle latency: at edge N, rDataX/rValidX capture the contents of entry rAddrX as sampled at edge N; both ports SHALL be independent and may address the same entry.
REQ-017 Write-to-read bypass: if at edge N we=1, wBe != 0 and rAddrX == wAddr, rDataX SHALL show the post-write merged value (new enabled bytes, old other bytes) and rValidX=1.
REQ-018 A read of a never-written entry SHALL return rDataX = 0 and rValidX = 0.
REQ-019 With R0_ZERO=1, writes to entry 0 SHALL be ignored, and reads of entry 0 SHALL return data 0 with rValidX=1, including under bypass.
REQ-020 Addresses SHALL be fully decoded with no wrap or alias; every ADDR_W value maps to a distinct entry.
REQ-021 The storage array SHALL be synthesisable as flip-flops and SHALL have no combinational path from inputs to rDataX/rValidX.

Reset
REQ-022 When reset=1 at a rising edge, all entries SHALL clear to 0, all valid bits SHALL clear, and rDataA/rDataB/rValidA/rValidB SHALL be 0 after that edge.
REQ-023 Reset SHALL take priority over a simultaneous write; the write SHALL be discarded.
REQ-024 At the first edge with reset=0, reads and writes SHALL resume normal behaviour with no extra idle cycle.

Verification
REQ-025 Basic write/read, DATA_W=32, ADDR_W=3: write 0xFFFFFFFF to entry 2, 0x12345678 to entry 6 and 0x37081534 to entry 1, all with wBe=4'hF; then read A=1, B=6 -> next cycle rDataA=0x37081534, rDataB=0x12345678, both valid=1.
REQ-026 Byte enable: entry 2 holds 0xFFFFFFFF; write 0x00AB0000 with wBe=4'b0100 -> a read returns 0xFFABFFFF.
REQ-027 Bypass: same edge we=1, wAddr=5, wData=0xDEADBEEF, wBe=4'hF, rAddrA=5 -> next cycle rDataA=0xDEADBEEF, rValidA=1.
REQ-028 Unwritten entry: after reset, read entry 4 on both ports -> rData=0, rValid=0.
REQ-029 Reset mid-operation: assert reset on the same edge as a write to entry 3 = 0x11111111, then read entry 3 -> data 0, valid 0.
REQ-030 R0_ZERO=1: write 0xAAAAAAAA to entry 0 while reading entry 0 -> rData=0, rValid=1.
